// File: rtl/out_bcd_pkg.sv
// Shared definitions for the out_bcd display-path converter (package out_pkg).
// Optional build macro used by this slice: OUT_BCD_SIGNED_EN.
package out_pkg;

  // Converter FSM: waiting for a value, or shifting one bit per enabled edge.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Smallest digit count d with 10**d > 2**width.
  // 2**width has floor(width*log10(2)) + 1 decimal digits, and a power of two
  // is never a power of ten for width >= 1, so that digit count is exact.
  function automatic int min_digits(input int width);
    int d;
    if (width <= 0) begin
      d = 1;
    end else begin
      d = int'((longint'(width) * 64'd30103) / 64'd100000) + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/out_bcd_if.sv
// Bus bundle between the display-path master and the out_bcd converter.
// Optional build macro used by this slice: OUT_BCD_SIGNED_EN.
interface out_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);

  logic                  clk_en;
  logic                  i_load_enable;
  logic [WIDTH-1:0]      i_load_data;
  logic [WIDTH-1:0]      o_data;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_neg;
  logic                  o_valid;
  logic                  o_busy;

  // Producer side: supplies the value and the global enable.
  modport master (
    output clk_en,
    output i_load_enable,
    output i_load_data,
    input  o_data,
    input  o_bcd,
    input  o_neg,
    input  o_valid,
    input  o_busy
  );

  // Converter side.
  modport slave (
    input  clk_en,
    input  i_load_enable,
    input  i_load_data,
    output o_data,
    output o_bcd,
    output o_neg,
    output o_valid,
    output o_busy
  );

endinterface

// File: rtl/out_bcd_digit_adj.sv
// Single BCD digit fixup for double dabble: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
// Optional build macro used by this slice: OUT_BCD_SIGNED_EN.
module bcd_digit_adj
  import out_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  logic w_ge_thresh;

  assign w_ge_thresh = (i_digit >= BCD_DIGIT_W'(ADD3_THRESH));
  assign o_digit     = w_ge_thresh ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/out_bcd.sv
// Display output register with sequential binary-to-BCD conversion.
// Latches a WIDTH-bit value, then runs shift-and-add-3 one bit per enabled
// clock; o_bcd only updates when a conversion completes.
// Build macro OUT_BCD_SIGNED_EN: treat the input as two's complement and
// convert its magnitude, reporting the sign on o_neg.
module out_bcd
  import out_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  out_bcd_if.slave  bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Reject digit counts that cannot hold every WIDTH-bit value.
  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("out_bcd: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [SCR_W-1:0]   r_scratch;
  logic [WIDTH-1:0]   r_data;
  logic [SCR_W-1:0]   r_bcd;
  logic               r_valid;
  logic               w_busy;

  logic               w_load;
  logic               w_last;
  logic [WIDTH-1:0]   w_operand;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_scratch_shift;
  logic [WIDTH-1:0]   w_shift_next;

  assign w_load = bus.clk_en & bus.i_load_enable;
  assign w_last = (r_count == CNT_W'(WIDTH - 1));

`ifdef OUT_BCD_SIGNED_EN
  logic w_in_neg;
  logic r_sign;
  logic r_neg;

  // Magnitude of a two's complement input; the most negative value wraps to
  // itself, which read as unsigned is exactly its magnitude.
  assign w_in_neg  = bus.i_load_data[WIDTH-1];
  assign w_operand = w_in_neg ? (~bus.i_load_data + WIDTH'(1)) : bus.i_load_data;

  // Sign latch captured at load, published alongside the finished digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_neg  <= 1'b0;
    end else if (bus.clk_en) begin
      if (w_load) begin
        r_sign <= w_in_neg;
      end else if (r_state == CONV && w_last) begin
        r_neg <= r_sign;
      end
    end
  end

  assign bus.o_neg = r_neg;
`else
  assign w_operand = bus.i_load_data;
  assign bus.o_neg = 1'b0;
`endif

  // One add-3 fixup per BCD digit of the scratch register.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjusted scratch shifted left, taking in the next binary bit (MSB first).
  assign w_scratch_shift = {w_adj[SCR_W-2:0], r_shift[WIDTH-1]};
  assign w_shift_next    = r_shift << 1;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a load always (re)starts; the last bit returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (bus.clk_en) begin
      if (w_load) begin
        w_state_next = CONV;
      end else if (r_state == CONV && w_last) begin
        w_state_next = IDLE;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    w_busy = 1'b0;
    if (r_state == CONV) begin
      w_busy = 1'b1;
    end
  end

  // Datapath: load capture, per-bit shift-and-add, and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      r_data    <= '0;
      r_bcd     <= '0;
      r_valid   <= 1'b1;
    end else if (bus.clk_en) begin
      if (w_load) begin
        r_data    <= bus.i_load_data;
        r_shift   <= w_operand;
        r_scratch <= '0;
        r_count   <= '0;
        r_valid   <= 1'b0;
      end else if (r_state == CONV) begin
        r_scratch <= w_scratch_shift;
        r_shift   <= w_shift_next;
        r_count   <= r_count + CNT_W'(1);
        if (w_last) begin
          r_bcd   <= w_scratch_shift;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_bcd   = r_bcd;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = w_busy;

endmodule
